estimador_vadd_sched: RTL and testbench

//  Round-robin scheduler that shares one saturating signed fixed-point vector adder
//  (W-bit, N-element, one element per cycle) between NREQ estimator requesters.

---
 rtl/estimador_vadd_sched_if.sv | 28 ++
 rtl/estimador_vadd_sched.sv | 136 +++++++++++++
 tb/tb_estimador_vadd_sched.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/estimador_vadd_sched_if.sv
// Requester/result bus of the shared saturating vector adder scheduler.
interface estimador_vadd_sched_if #(
    parameter int unsigned W    = 21,
    parameter int unsigned N    = 3,
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N*W-1:0] req_a;
    logic [NREQ*N*W-1:0] req_b;
    logic [N*W-1:0]      res_data;
    logic                res_vld;
    logic [ID_W-1:0]     res_id;
    logic                busy;

    // Requester side: drives operands, observes grants and results.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_data, res_vld, res_id, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_data, res_vld, res_id, busy
    );
endinterface

// File: rtl/estimador_vadd_sched.sv
// Round-robin scheduler sharing one saturating signed vector adder (one element/cycle).
module estimador_vadd_sched #(
    parameter int unsigned W    = 21,
    parameter int unsigned N    = 3,
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    estimador_vadd_sched_if.slave   bus
);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned VW    = N * W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [VW-1:0]   a_q, a_d, b_q, b_d;
    logic [VW-1:0]   res_data_q, res_data_d;
    logic            res_vld_q, res_vld_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] ready_c;
    logic            grant_vld_c;
    logic [ID_W-1:0] grant_c;
    logic [ID_W-1:0] scan_c;
    logic [W-1:0]    a_e_c, b_e_c, sat_c;
    logic [W:0]      sum_c;

    // Round-robin search for the first valid requester starting at rr_ptr.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        scan_c      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_c = ID_W'((32'(rr_ptr_q) + i) % NREQ);
            if (!grant_vld_c && bus.req_valid[scan_c]) begin
                grant_vld_c = 1'b1;
                grant_c     = scan_c;
            end
        end
    end

    // Saturating add of the current element at W+1 bits.
    always_comb begin
        a_e_c = a_q[32'(elem_cnt_q) * W +: W];
        b_e_c = b_q[32'(elem_cnt_q) * W +: W];
        sum_c = {a_e_c[W-1], a_e_c} + {b_e_c[W-1], b_e_c};
        if (sum_c[W] != sum_c[W-1]) begin
            sat_c = sum_c[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_c = sum_c[W-1:0];
        end
    end

    // Next-state and datapath updates for IDLE -> RUN -> DONE sequencing.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        elem_cnt_d = elem_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_vld_d  = 1'b0;
        busy_d     = busy_q;
        ready_c    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld_c) begin
                    ready_c[grant_c] = 1'b1;
                    a_d        = bus.req_a[32'(grant_c) * VW +: VW];
                    b_d        = bus.req_b[32'(grant_c) * VW +: VW];
                    id_d       = grant_c;
                    rr_ptr_d   = ID_W'((32'(grant_c) + 1) % NREQ);
                    elem_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                res_data_d[32'(elem_cnt_q) * W +: W] = sat_c;
                if (elem_cnt_q == CNT_W'(N - 1)) begin
                    elem_cnt_d = '0;
                    res_vld_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    elem_cnt_d = elem_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            elem_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            elem_cnt_q <= elem_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_vld_q  <= res_vld_d;
            busy_q     <= busy_d;
        end
    end

    // A grant is never offered while reset is being applied at this edge.
    assign bus.req_ready = ready_c & {NREQ{ap_rst_n}};
    assign bus.res_data  = res_data_q;
    assign bus.res_vld   = res_vld_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_estimador_vadd_sched.sv
// Randomized + directed bench for estimador_vadd_sched with a scoreboard and reference model.
module tb_estimador_vadd_sched;
    localparam int W    = 21;
    localparam int N    = 3;
    localparam int NREQ = 2;
    localparam int ID_W = 1;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    typedef struct {
        int             id;
        logic [N*W-1:0] data;
        int             due;
    } exp_t;

    logic ap_clk;
    logic ap_rst_n;

    estimador_vadd_sched_if #(.W(W), .N(N), .NREQ(NREQ), .ID_W(ID_W)) bus ();

    estimador_vadd_sched #(.W(W), .N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          opa [NREQ][N];
    int          opb [NREQ][N];
    bit          hold [NREQ];
    logic [NREQ-1:0] gnt_seen = '0;
    int          gnt_cnt [NREQ];
    int          id_hist [$];
    exp_t        sb [$];
    int          m_rr   = 0;
    int          m_free = 0;
    bit          chk_zero = 1'b0;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial forever begin
        @(posedge ap_clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s act=0x%0h exp=0x%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int a, input int b);
        int s;
        s = a + b;
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
    endfunction

    function automatic logic [N*W-1:0] exp_vec(input int k);
        logic [N*W-1:0] v;
        logic [W-1:0]   e;
        v = '0;
        for (int i = 0; i < N; i++) begin
            e = W'(sat(opa[k][i], opb[k][i]));
            v[i*W +: W] = e;
        end
        return v;
    endfunction

    function automatic int rand_op();
        case ($urandom_range(0, 4))
            0:       return MAXV;
            1:       return MINV;
            2:       return int'($urandom_range(0, 7)) - 4;
            default: return int'($urandom_range(0, 2 * MAXV + 1)) + MINV;
        endcase
    endfunction

    task automatic pack_ops();
        logic [W-1:0] t;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < N; i++) begin
                t = W'(opa[k][i]);
                bus.req_a[(k*N+i)*W +: W] = t;
                t = W'(opb[k][i]);
                bus.req_b[(k*N+i)*W +: W] = t;
            end
        end
    endtask

    task automatic new_ops(input int k);
        for (int i = 0; i < N; i++) begin
            opa[k][i] = rand_op();
            opb[k][i] = rand_op();
        end
        pack_ops();
    endtask

    // Advance one cycle; a requester that saw req_ready drops or renews its request.
    task automatic tick();
        @(posedge ap_clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_seen[k]) begin
                if (hold[k]) new_ops(k);
                else bus.req_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        bus.req_valid = '0;
        tick();
        tick();
        ap_rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.req_valid != '0 || bus.busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'(n), 64'(0));
    endtask

    task automatic wait_grant(input int k, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!gnt_seen[k] && n < 50);
        chk(name, 64'(gnt_seen[k]), 64'(1));
    endtask

    // Monitor: spec-level model of arbitration, timing and results, checked mid-cycle.
    initial forever begin
        logic [NREQ-1:0] exp_rdy;
        bit              exp_vld;
        int              k, g;
        exp_t            e;
        @(negedge ap_clk);
        exp_rdy = '0;
        g = -1;
        if (ap_rst_n && cyc >= m_free) begin
            for (int i = 0; i < NREQ; i++) begin
                k = (m_rr + i) % NREQ;
                if (g < 0 && bus.req_valid[k]) begin
                    exp_rdy[k] = 1'b1;
                    g = k;
                end
            end
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (ap_rst_n) begin
            chk("busy", 64'(bus.busy), 64'(cyc < m_free));
            exp_vld = (sb.size() != 0) && (sb[0].due == cyc);
            chk("res_vld", 64'(bus.res_vld), 64'(exp_vld));
            if (bus.res_vld) id_hist.push_back(int'(bus.res_id));
            if (exp_vld) begin
                e = sb.pop_front();
                chk("res_id", 64'(bus.res_id), 64'(e.id));
                chk("res_data", 64'(bus.res_data), 64'(e.data));
            end
            if (chk_zero) begin
                chk("res_data_after_reset", 64'(bus.res_data), 64'(0));
                chk_zero = 1'b0;
            end
        end
        for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) gnt_cnt[j] = gnt_cnt[j] + 1;
        gnt_seen = bus.req_ready;
        if (!ap_rst_n) begin
            sb.delete();
            m_rr     = 0;
            m_free   = cyc + 1;
            chk_zero = 1'b1;
        end else if (g >= 0) begin
            e.id   = g;
            e.data = exp_vec(g);
            e.due  = cyc + N + 1;
            sb.push_back(e);
            m_rr   = (g + 1) % NREQ;
            m_free = cyc + N + 2;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1;
        ap_rst_n      = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            hold[k]    = 1'b0;
            gnt_cnt[k] = 0;
            for (int i = 0; i < N; i++) begin
                opa[k][i] = 0;
                opb[k][i] = 0;
            end
        end
        do_reset();
        @(negedge ap_clk);
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_vld", 64'(bus.res_vld), 64'(0));
        chk("reset_data", 64'(bus.res_data), 64'(0));
        chk("reset_id", 64'(bus.res_id), 64'(0));

        // Plain sums on requester 0.
        tick();
        opa[0] = '{5, -3, 100};
        opb[0] = '{7, 3, -200};
        pack_ops();
        bus.req_valid[0] = 1'b1;
        wait_idle();

        // Saturation boundaries on requester 1.
        opa[1] = '{MAXV, MINV, MAXV};
        opb[1] = '{1, -1, 0};
        pack_ops();
        bus.req_valid[1] = 1'b1;
        wait_idle();

        // Both requesters after reset: req0 first, then req1.
        do_reset();
        new_ops(0);
        new_ops(1);
        bus.req_valid = 2'b11;
        wait_idle();

        // Continuous requests alternate strictly.
        id_hist.delete();
        g1 = gnt_cnt[0] + gnt_cnt[1];
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        new_ops(0);
        new_ops(1);
        bus.req_valid = 2'b11;
        for (int n = 0; n < 100 && (gnt_cnt[0] + gnt_cnt[1]) < g1 + 6; n++) tick();
        bus.req_valid = '0;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        wait_idle();
        chk("alt_count", 64'(id_hist.size()), 64'(6));
        for (int j = 0; j < id_hist.size() && j < 6; j++) chk("alt_id", 64'(id_hist[j]), 64'(j % 2));

        // Reset during the second RUN cycle discards the operation and clears rr_ptr.
        new_ops(0);
        bus.req_valid[0] = 1'b1;
        wait_grant(0, "t5_grant");
        new_ops(0);
        new_ops(1);
        bus.req_valid = 2'b11;
        tick();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("t5_busy", 64'(bus.busy), 64'(0));
        chk("t5_data", 64'(bus.res_data), 64'(0));
        chk("t5_vld", 64'(bus.res_vld), 64'(0));
        chk("t5_ready", 64'(bus.req_ready), 64'(2'b01));
        wait_idle();

        // Request withdrawn while the adder is busy is never granted.
        new_ops(0);
        bus.req_valid[0] = 1'b1;
        wait_grant(0, "t6_grant");
        g1 = gnt_cnt[1];
        new_ops(1);
        bus.req_valid[1] = 1'b1;
        tick();
        tick();
        bus.req_valid[1] = 1'b0;
        wait_idle();
        chk("t6_no_grant", 64'(gnt_cnt[1]), 64'(g1));

        // Random traffic with occasional withdrawals.
        for (int n = 0; n < 600; n++) begin
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.req_valid[k]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        new_ops(k);
                        bus.req_valid[k] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req_valid[k] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
